lcd_nibble_tx: RTL

//  Downstream stage of the LCD init/text sequencer. Queues 5-bit commands ({RS, D[3:0]}) with per-command settle delay.

---
 rtl/lcd_nibble_tx.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx: queued 4-bit HD44780 writer (setup, E pulse, hold, settle delay) with commandDone per command.
// Optional LCD_TX_MIN_DELAY_EN raises every settle delay to at least MIN_DELAY_CYC.
module lcd_nibble_tx #(
    parameter int FIFO_DEPTH    = 4,
    parameter int DELAY_W       = 21,
    parameter int SETUP_CYC     = 2,
    parameter int E_PULSE_CYC   = 12,
    parameter int HOLD_CYC      = 2,
    parameter int MIN_DELAY_CYC = 50
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               sendCommand,
    input  logic [4:0]         command,
    input  logic [DELAY_W-1:0] commandDelay,
    output logic               cmdReady,
    output logic               commandDone,
    output logic               overflow,
    output logic [4:0]         LCD_D,
    output logic               LCD_E
);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int PH_A   = (SETUP_CYC > E_PULSE_CYC) ? SETUP_CYC : E_PULSE_CYC;
    localparam int PH_MAX = (PH_A > HOLD_CYC) ? PH_A : HOLD_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int CNT_W  = (DELAY_W > PH_W) ? DELAY_W : PH_W;
`ifdef LCD_TX_MIN_DELAY_EN
    localparam bit MIN_EN = 1'b1;
`else
    localparam bit MIN_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT} state_t;

    logic [4:0]         r_cmd_mem [FIFO_DEPTH];
    logic [DELAY_W-1:0] r_dly_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [AW:0]        r_count;
    logic               r_ovf;

    state_t             r_state, w_state_nx;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic [DELAY_W-1:0] r_delay, w_delay_nx;
    logic [4:0]         r_lcd_d, w_lcd_d_nx;
    logic               r_lcd_e, w_lcd_e_nx;
    logic               r_done, w_done_nx;

    logic               w_full, w_empty, w_push, w_pop;
    logic [DELAY_W-1:0] w_head_dly, w_pop_delay;

    assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = sendCommand & (~w_full | w_pop);
    assign w_head_dly  = r_dly_mem[r_rd_ptr];
    assign w_pop_delay = (MIN_EN && (w_head_dly < DELAY_W'(MIN_DELAY_CYC)))
                         ? DELAY_W'(MIN_DELAY_CYC) : w_head_dly;

    assign cmdReady    = ~w_full;
    assign commandDone = r_done;
    assign overflow    = r_ovf;
    assign LCD_D       = r_lcd_d;
    assign LCD_E       = r_lcd_e;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_cmd_mem[r_wr_ptr] <= command;
            r_dly_mem[r_wr_ptr] <= commandDelay;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (sendCommand && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_delay <= '0;
            r_lcd_d <= '0;
            r_lcd_e <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_delay <= w_delay_nx;
            r_lcd_d <= w_lcd_d_nx;
            r_lcd_e <= w_lcd_e_nx;
            r_done  <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_delay_nx = r_delay;
        w_lcd_d_nx = r_lcd_d;
        w_lcd_e_nx = r_lcd_e;
        w_done_nx  = 1'b0;
        w_pop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_lcd_d_nx = r_cmd_mem[r_rd_ptr];
                    w_delay_nx = w_pop_delay;
                    w_cnt_nx   = CNT_W'(SETUP_CYC - 1);
                    w_state_nx = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_cnt == '0) begin
                    w_lcd_e_nx = 1'b1;
                    w_cnt_nx   = CNT_W'(E_PULSE_CYC - 1);
                    w_state_nx = S_PULSE;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            S_PULSE: begin
                if (r_cnt == '0) begin
                    w_lcd_e_nx = 1'b0;
                    w_cnt_nx   = CNT_W'(HOLD_CYC);
                    w_state_nx = S_HOLD;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            // HOLD runs one cycle past HOLD_CYC so done lands 2+setup+pulse+hold+delay edges after accept
            S_HOLD: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end else if (r_delay == '0) begin
                    w_done_nx  = 1'b1;
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx   = CNT_W'(r_delay) - CNT_W'(1);
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_done_nx  = 1'b1;
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end
endmodule
